// File: rtl/wb_stage_if.sv
// EX -> WB bundle: decoded controls and results from EX, plus register-bank writes,
// flags and branch redirect going back upstream.
interface wb_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          ex_valid;
    logic          wb_stall;
    logic [DW-1:0] alu_result;
    logic          alu_O, alu_S, alu_C, alu_Z;
    logic [DW-1:0] dm_Q;
    logic [DW-1:0] pc_link;
    logic [3:0]    uc_WF;
    logic [1:0]    uc_S_MXWB;
    logic          uc_WE_RB;
    logic [AW-1:0] uc_WA;
    logic          uc_BR;
    logic          tf_out;

    logic          rb_WE;
    logic [AW-1:0] rb_WA;
    logic [DW-1:0] rb_WD;
    logic          rf_O, rf_S, rf_C, rf_Z;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic          flushing;
    logic [31:0]   retire_cnt;

    modport master (
        output ex_valid, wb_stall, alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, pc_link,
               uc_WF, uc_S_MXWB, uc_WE_RB, uc_WA, uc_BR, tf_out,
        input  rb_WE, rb_WA, rb_WD, rf_O, rf_S, rf_C, rf_Z, br_taken, br_target,
               flushing, retire_cnt
    );

    modport slave (
        input  ex_valid, wb_stall, alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, pc_link,
               uc_WF, uc_S_MXWB, uc_WE_RB, uc_WA, uc_BR, tf_out,
        output rb_WE, rb_WA, rb_WD, rf_O, rf_S, rf_C, rf_Z, br_taken, br_target,
               flushing, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers EX results, selects register-bank write data, owns the
// O/S/C/Z flag register and squashes the instructions fetched behind a taken branch.
module wb_stage #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    wb_stage_if.slave bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 2);
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [3:0]    flags_q, flags_d;
    logic          br_q, br_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [31:0]   retire_q, retire_d;

    logic          accept, squash, taken;
    logic [3:0]    alu_flags;
    logic [DW-1:0] wd_sel;

    assign accept    = bus.ex_valid & ~bus.wb_stall & (state_q == S_RUN);
    assign squash    = bus.ex_valid & ~bus.wb_stall & (state_q == S_FLUSH);
    assign taken     = accept & bus.uc_BR & bus.tf_out;
    assign alu_flags = {bus.alu_O, bus.alu_S, bus.alu_C, bus.alu_Z};

    always_comb begin
        case (bus.uc_S_MXWB)
            2'd1:    wd_sel = bus.dm_Q;
            2'd2:    wd_sel = bus.pc_link;
            default: wd_sel = bus.alu_result;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        br_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        flags_d  = flags_q;
        tgt_d    = tgt_q;
        retire_d = retire_q;
        if (accept) begin
            we_d     = bus.uc_WE_RB;
            wa_d     = bus.uc_WA;
            wd_d     = wd_sel;
            retire_d = retire_q + 32'd1;
            for (int i = 0; i < 4; i++)
                flags_d[i] = bus.uc_WF[i] ? alu_flags[i] : flags_q[i];
            // A taken branch still performs its own link write and flag update.
            if (taken) begin
                br_d  = 1'b1;
                tgt_d = bus.alu_result;
                if (FLUSH_CYCLES > 0) begin
                    state_d = S_FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES);
                end
            end
        end
        // Only valid instructions consume flush slots; bubbles do not.
        if (squash) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                state_d = S_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            flags_q  <= '0;
            br_q     <= 1'b0;
            tgt_q    <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            flags_q  <= flags_d;
            br_q     <= br_d;
            tgt_q    <= tgt_d;
            retire_q <= retire_d;
        end
    end

    assign bus.rb_WE      = we_q;
    assign bus.rb_WA      = wa_q;
    assign bus.rb_WD      = wd_q;
    assign bus.rf_O       = flags_q[3];
    assign bus.rf_S       = flags_q[2];
    assign bus.rf_C       = flags_q[1];
    assign bus.rf_Z       = flags_q[0];
    assign bus.br_taken   = br_q;
    assign bus.br_target  = tgt_q;
    assign bus.flushing   = (state_q == S_FLUSH);
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: directed scenarios then random traffic, every
// cycle's expected outputs queued by the driver and checked by an independent monitor.
module tb_wb_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FC = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [3:0]    flags;
        logic          br;
        logic [DW-1:0] tgt;
        logic          flushing;
        logic [31:0]   retire;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    exp_t mdl;
    int   flush_left;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_stage_if #(.DW(DW), .AW(AW)) bus ();

    wb_stage #(.DW(DW), .AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl = '{we: 1'b0, wa: '0, wd: '0, flags: 4'b0, br: 1'b0, tgt: '0,
                flushing: 1'b0, retire: 32'd0};
        flush_left = 0;
    endtask

    // Drive one cycle's inputs (caller is at a negedge), advance the reference model,
    // queue the outputs expected after the coming posedge, then wait for the next negedge.
    task automatic step(input logic v, input logic st, input logic [31:0] alu,
                        input logic [3:0] af, input logic [31:0] dm, input logic [31:0] pc,
                        input logic [3:0] wf, input logic [1:0] sel, input logic we,
                        input logic [4:0] wa, input logic br, input logic tf);
        bus.ex_valid = v;   bus.wb_stall = st;  bus.alu_result = alu;
        {bus.alu_O, bus.alu_S, bus.alu_C, bus.alu_Z} = af;
        bus.dm_Q = dm;      bus.pc_link = pc;   bus.uc_WF = wf;
        bus.uc_S_MXWB = sel; bus.uc_WE_RB = we; bus.uc_WA = wa;
        bus.uc_BR = br;     bus.tf_out = tf;

        mdl.we = 1'b0;
        mdl.br = 1'b0;
        if (v && !st) begin
            if (flush_left > 0) begin
                flush_left--;
            end else begin
                mdl.we = we;
                mdl.wa = wa;
                mdl.wd = (sel == 2'd1) ? dm : (sel == 2'd2) ? pc : alu;
                mdl.flags = (mdl.flags & ~wf) | (af & wf);
                mdl.retire = mdl.retire + 32'd1;
                if (br && tf) begin
                    mdl.br = 1'b1;
                    mdl.tgt = alu;
                    flush_left = FC;
                end
            end
        end
        mdl.flushing = (flush_left > 0);
        sb.push_back(mdl);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic instr(input logic [31:0] alu, input logic [4:0] wa);
        step(1'b1, 1'b0, alu, 4'hF, 32'h0, 32'h0, 4'h0, 2'd0, 1'b1, wa, 1'b0, 1'b0);
    endtask

    task automatic branch(input logic [31:0] tgt);
        step(1'b1, 1'b0, tgt, 4'h0, 32'h0, 32'h0, 4'h0, 2'd2, 1'b1, 5'd31, 1'b1, 1'b1);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        bus.wb_stall = 1'b0;
        #1;
        chk("rst_async_flushing", {31'd0, bus.flushing}, 32'd0);
        chk("rst_async_retire", bus.retire_cnt, 32'd0);
        chk("rst_async_we", {31'd0, bus.rb_WE}, 32'd0);
        model_reset();
        sb.push_back(mdl);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rb_WE", {31'd0, bus.rb_WE}, {31'd0, e.we});
                chk("rb_WA", {27'd0, bus.rb_WA}, {27'd0, e.wa});
                chk("rb_WD", bus.rb_WD, e.wd);
                chk("flags", {28'd0, bus.rf_O, bus.rf_S, bus.rf_C, bus.rf_Z}, {28'd0, e.flags});
                chk("br_taken", {31'd0, bus.br_taken}, {31'd0, e.br});
                chk("br_target", bus.br_target, e.tgt);
                chk("flushing", {31'd0, bus.flushing}, {31'd0, e.flushing});
                chk("retire_cnt", bus.retire_cnt, e.retire);
            end
        end
    end

    initial begin : driver
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic ALU write, then dm_Q and link selects, then idle holds data.
        step(1, 0, 32'd5, 4'h0, 32'h0, 32'h0, 4'h0, 2'd0, 1, 5'd3, 0, 0);
        step(1, 0, 32'd7, 4'h0, 32'hDEADBEEF, 32'h0, 4'h0, 2'd1, 1, 5'd4, 0, 0);
        step(1, 0, 32'd9, 4'h0, 32'h0, 32'h40, 4'h0, 2'd2, 1, 5'd5, 0, 0);
        step(1, 0, 32'd11, 4'h0, 32'h0, 32'h0, 4'h0, 2'd3, 1, 5'd6, 0, 0);
        idle();
        idle();

        // Flag mask: only C,Z update, then an all-zero mask changes nothing.
        step(1, 0, 32'd1, 4'b1111, 32'h0, 32'h0, 4'b0011, 2'd0, 0, 5'd0, 0, 0);
        step(1, 0, 32'd2, 4'b0000, 32'h0, 32'h0, 4'b0000, 2'd0, 0, 5'd0, 0, 0);
        step(1, 0, 32'd3, 4'b1100, 32'h0, 32'h0, 4'b1000, 2'd0, 1, 5'd7, 0, 0);

        // Not-taken branch retires normally.
        step(1, 0, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 2'd0, 1, 5'd8, 1, 0);

        // Taken branch; a bubble inside the flush window does not shorten it,
        // and a taken-looking branch inside the window is squashed.
        branch(32'h100);
        instr(32'hAA, 5'd9);
        idle();
        branch(32'h300);
        instr(32'hBB, 5'd10);

        // Stall in RUN, then stall mid-flush.
        step(1, 1, 32'hCC, 4'hF, 32'h0, 32'h0, 4'hF, 2'd0, 1, 5'd11, 0, 0);
        step(1, 1, 32'hCC, 4'hF, 32'h0, 32'h0, 4'hF, 2'd0, 1, 5'd11, 0, 0);
        step(1, 1, 32'hCC, 4'hF, 32'h0, 32'h0, 4'hF, 2'd0, 1, 5'd11, 0, 0);
        step(1, 0, 32'hCC, 4'hF, 32'h0, 32'h0, 4'hF, 2'd0, 1, 5'd11, 0, 0);
        branch(32'h400);
        instr(32'h1, 5'd1);
        for (int i = 0; i < 3; i++)
            step(1, 1, 32'h2, 4'h0, 32'h0, 32'h0, 4'h0, 2'd0, 1, 5'd2, 0, 0);
        instr(32'h2, 5'd2);
        instr(32'h3, 5'd3);

        // Retire counter wrap.
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        mdl.retire = 32'hFFFF_FFFF;
        instr(32'h5, 5'd5);
        instr(32'h6, 5'd6);

        // Reset in the middle of a flush window.
        branch(32'h500);
        instr(32'h7, 5'd7);
        do_reset();
        instr(32'h8, 5'd8);
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), $urandom, 4'($urandom),
                 $urandom, $urandom, 4'($urandom), sel, 1'($urandom), 5'($urandom),
                 ($urandom_range(0, 4) == 0), 1'($urandom));
        end
        idle();
        idle();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
